// File: rtl/modem_loopback_bist.sv
// modem_loopback_bist: PRBS-9 loopback self-test sequencer for the modem TX/RX halves
module modem_loopback_bist #(
   parameter int RST_CYCLES  = 64,
   parameter int WARM_CYCLES = 1024,
   parameter int TIMEOUT     = 1048576,
   parameter int TO_W        = 21
) (
   input  logic        clk_h,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] n_bytes,
   input  logic        corr_pr_detect,
   output logic        switch_on,
   output logic        tx_run,
   output logic        rx_run,
   output logic [7:0]  bist_tdata,
   output logic        bist_tvalid,
   input  logic        bist_tready,
   input  logic [7:0]  rx_tdata,
   input  logic        rx_tvalid,
   output logic        rx_tready,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic        det_seen,
   output logic [15:0] err_cnt,
   output logic [15:0] rx_cnt
);
   typedef enum logic [2:0] {IDLE, RESET, RX_WARM, TX_RUN, DRAIN, DONE, FAIL} state_t;
   state_t state, nxt;
   logic [TO_W-1:0] tmr;
   logic [15:0] n_lat, tx_cnt, err_nxt, rx_nxt;
   logic [8:0] tx_lfsr, rx_lfsr, tx_lfsr_nxt, rx_lfsr_nxt;
   logic [7:0] tx_byte, rx_byte;
   logic idle_st, run_st, go, tx_hs, rx_hit, rx_err, last_tx, last_rx, tmr_end, det_nxt, done_in, fail_in;

   function automatic logic [16:0] prbs_byte(input logic [8:0] seed);
      logic [8:0] s;
      logic [7:0] b;
      s = seed;
      b = '0;
      for (int i = 7; i >= 0; i--) begin
         b[i] = s[8];
         s = {s[7:0], s[8] ^ s[4]};
      end
      return {b, s};
   endfunction

   assign {tx_byte, tx_lfsr_nxt} = prbs_byte(tx_lfsr);
   assign {rx_byte, rx_lfsr_nxt} = prbs_byte(rx_lfsr);
   assign idle_st = state inside {IDLE, DONE, FAIL};
   assign run_st  = state inside {TX_RUN, DRAIN};
   assign go      = idle_st & start & ~abort & (n_bytes != 16'd0);
   assign tx_hs   = bist_tvalid & bist_tready;
   assign rx_hit  = run_st & rx_tvalid;
   assign rx_err  = rx_hit & (rx_tdata != rx_byte);
   assign err_nxt = (rx_err && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
   assign rx_nxt  = (rx_hit && rx_cnt != 16'hFFFF) ? rx_cnt + 16'd1 : rx_cnt;
   assign last_rx = rx_hit & (rx_nxt == n_lat);
   assign last_tx = tx_hs & (tx_cnt + 16'd1 == n_lat);
   assign tmr_end = tmr == TO_W'(TIMEOUT - 1);
   assign det_nxt = det_seen | (corr_pr_detect & (run_st | (state == RX_WARM)));
   assign done_in = run_st & (nxt == DONE);
   assign fail_in = run_st & (nxt == FAIL);

   // state register
   always_ff @(posedge clk_h or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;

   // next state (abort beats start, completion beats timeout) and state-decoded enables
   always_comb begin
      nxt = (abort & ~idle_st) ? IDLE :
            go ? RESET :
            (state == RESET && tmr == TO_W'(RST_CYCLES - 1)) ? RX_WARM :
            (state == RX_WARM && tmr == TO_W'(WARM_CYCLES - 1)) ? TX_RUN :
            !run_st ? state :
            last_rx ? DONE :
            tmr_end ? FAIL :
            last_tx ? DRAIN : state;
      switch_on = ~idle_st;
      busy = ~idle_st;
      rx_run = run_st | (state == RX_WARM);
      tx_run = run_st;
      bist_tvalid = state == TX_RUN;
      bist_tdata = bist_tvalid ? tx_byte : 8'h00;
   end

   // phase timer, PRBS generators, byte counters and held results
   always_ff @(posedge clk_h or posedge rst)
      if (rst) begin
         tmr <= '0;
         n_lat <= '0;
         tx_cnt <= '0;
         tx_lfsr <= 9'h1FF;
         rx_lfsr <= 9'h1FF;
         err_cnt <= '0;
         rx_cnt <= '0;
         pass <= 1'b0;
         timeout <= 1'b0;
         det_seen <= 1'b0;
         done <= 1'b0;
         rx_tready <= 1'b0;
      end else begin
         rx_tready <= 1'b1;
         tmr <= (nxt == state || nxt == DRAIN) ? tmr + TO_W'(1) : '0;
         done <= done_in | fail_in;
         if (go) begin
            n_lat <= n_bytes;
            tx_cnt <= '0;
            tx_lfsr <= 9'h1FF;
            rx_lfsr <= 9'h1FF;
            err_cnt <= '0;
            rx_cnt <= '0;
            pass <= 1'b0;
            timeout <= 1'b0;
            det_seen <= 1'b0;
         end else begin
            det_seen <= det_nxt;
            err_cnt <= err_nxt;
            rx_cnt <= rx_nxt;
            if (rx_hit) rx_lfsr <= rx_lfsr_nxt;
            if (tx_hs) begin
               tx_lfsr <= tx_lfsr_nxt;
               tx_cnt <= tx_cnt + 16'd1;
            end
            if (abort & ~idle_st) pass <= 1'b0;
            else if (done_in) pass <= (err_nxt == 16'd0) & det_nxt;
            else if (fail_in) begin
               pass <= 1'b0;
               timeout <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_modem_loopback_bist.sv
// tb_modem_loopback_bist: table-driven loopback runs plus sequencing/abort/reset corner cases
module tb_modem_loopback_bist;
   localparam int RST_C = 8, WARM_C = 16, TO_C = 256, DLY = 20, MAXB = 16;

   logic clk_h = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic corr_pr_detect = 1'b0, bist_tready = 1'b0, rx_tvalid = 1'b0;
   logic [15:0] n_bytes = '0;
   logic [7:0] rx_tdata = '0;
   logic switch_on, tx_run, rx_run, bist_tvalid, rx_tready, busy, done, pass, timeout, det_seen;
   logic [7:0] bist_tdata;
   logic [15:0] err_cnt, rx_cnt;

   typedef struct {
      int n; bit bp; int flip; bit det; bit silent;
      int e_err; int e_rx; bit e_pass; bit e_to; bit e_det;
   } vec_t;
   typedef struct {logic [7:0] b; int due;} lb_t;

   vec_t vecs[7];
   logic [7:0] prbs_tab[MAXB];
   logic [7:0] tx_exp_q[$];
   lb_t lb_q[$];
   int n_cmp = 0, n_bad = 0, cyc = 0, hs_cnt = 0, rx_idx = 0, flip_idx = -1;
   bit bp_mode = 0, loop_en = 0, det_en = 0, prev_stall = 0;
   logic [7:0] prev_data = '0;

   modem_loopback_bist #(.RST_CYCLES(RST_C), .WARM_CYCLES(WARM_C), .TIMEOUT(TO_C), .TO_W(9)) dut (
      .clk_h(clk_h), .rst(rst), .start(start), .abort(abort), .n_bytes(n_bytes),
      .corr_pr_detect(corr_pr_detect), .switch_on(switch_on), .tx_run(tx_run), .rx_run(rx_run),
      .bist_tdata(bist_tdata), .bist_tvalid(bist_tvalid), .bist_tready(bist_tready),
      .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .busy(busy),
      .done(done), .pass(pass), .timeout(timeout), .det_seen(det_seen),
      .err_cnt(err_cnt), .rx_cnt(rx_cnt));

   always #5 clk_h = ~clk_h;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // environment: TX sink with optional backpressure, TX scoreboard, delayed RX loopback
   initial forever begin
      lb_t lb;
      @(negedge clk_h);
      cyc++;
      bist_tready = bp_mode ? ~bist_tready : 1'b1;
      if (prev_stall && bist_tvalid) chk("stall_hold", int'(bist_tdata), int'(prev_data));
      prev_stall = bist_tvalid & ~bist_tready;
      prev_data = bist_tdata;
      corr_pr_detect = 1'b0;
      if (bist_tvalid && bist_tready) begin
         hs_cnt++;
         if (det_en && hs_cnt == 1) corr_pr_detect = 1'b1;
         chk("tx_expected_left", int'(tx_exp_q.size() != 0), 1);
         if (tx_exp_q.size() != 0) chk("tx_data", int'(bist_tdata), int'(tx_exp_q.pop_front()));
         if (loop_en) lb_q.push_back('{bist_tdata, cyc + DLY});
      end
      rx_tvalid = 1'b0;
      if (lb_q.size() != 0 && lb_q[0].due <= cyc) begin
         lb = lb_q.pop_front();
         rx_tdata = (rx_idx == flip_idx) ? lb.b ^ 8'h01 : lb.b;
         rx_tvalid = 1'b1;
         rx_idx++;
      end
   end

   task automatic setup_env(input vec_t v);
      tx_exp_q.delete();
      lb_q.delete();
      bp_mode = v.bp;
      loop_en = !v.silent;
      flip_idx = v.flip;
      det_en = v.det;
      hs_cnt = 0;
      rx_idx = 0;
      for (int i = 0; i < v.n; i++) tx_exp_q.push_back(prbs_tab[i]);
   endtask

   task automatic run_test(input vec_t v);
      int sw_k, rx_k, tx_k, txc;
      bit got;
      setup_env(v);
      sw_k = -1; rx_k = -1; tx_k = -1; txc = 0; got = 0;
      @(negedge clk_h);
      n_bytes = 16'(v.n);
      start = 1'b1;
      @(negedge clk_h);
      start = 1'b0;
      chk("busy_on_start", int'(busy), 1);
      for (int k = 0; k < 3000 && !got; k++) begin
         if (switch_on && sw_k < 0) sw_k = k;
         if (rx_run && rx_k < 0) rx_k = k;
         if (tx_run && tx_k < 0) tx_k = k;
         if (tx_run) txc++;
         if (done) got = 1;
         else @(negedge clk_h);
      end
      chk("done_seen", int'(got), 1);
      chk("switch_with_busy", sw_k, 0);
      chk("rx_run_delay", rx_k - sw_k, RST_C);
      chk("tx_run_delay", tx_k - rx_k, WARM_C);
      chk("handshakes", hs_cnt, v.n);
      chk("err_cnt", int'(err_cnt), v.e_err);
      chk("rx_cnt", int'(rx_cnt), v.e_rx);
      chk("pass", int'(pass), int'(v.e_pass));
      chk("timeout", int'(timeout), int'(v.e_to));
      chk("det_seen", int'(det_seen), int'(v.e_det));
      chk("switch_off_end", int'(switch_on), 0);
      chk("busy_off_end", int'(busy), 0);
      if (v.silent) chk("timeout_cycles", txc, TO_C);
      @(negedge clk_h);
      chk("done_one_cycle", int'(done), 0);
      chk("pass_held", int'(pass), int'(v.e_pass));
   endtask

   initial begin
      bit c[8*MAXB];
      bit seen;
      int k;
      for (int i = 0; i < 8 * MAXB; i++) c[i] = (i < 9) ? 1'b1 : c[i-9] ^ c[i-5];
      for (int j = 0; j < MAXB; j++)
         for (int b = 0; b < 8; b++) prbs_tab[j][7-b] = c[8*j+b];
      //          n  bp flip det sil err rx pass to det
      vecs[0] = '{ 4, 0, -1, 1, 0, 0,  4, 1, 0, 1};
      vecs[1] = '{ 8, 0,  3, 1, 0, 1,  8, 0, 0, 1};
      vecs[2] = '{ 6, 1, -1, 1, 0, 0,  6, 1, 0, 1};
      vecs[3] = '{ 4, 0, -1, 1, 1, 0,  0, 0, 1, 1};
      vecs[4] = '{ 5, 0, -1, 0, 0, 0,  5, 0, 0, 0};
      vecs[5] = '{ 1, 0,  0, 1, 0, 1,  1, 0, 0, 1};
      vecs[6] = '{12, 1, 11, 1, 0, 1, 12, 0, 0, 1};

      repeat (3) @(negedge clk_h);
      chk("rst_rx_tready", int'(rx_tready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_switch", int'(switch_on), 0);
      rst = 1'b0;
      @(negedge clk_h);
      chk("rx_tready_after_rst", int'(rx_tready), 1);
      chk("idle_tvalid", int'(bist_tvalid), 0);
      chk("idle_tdata", int'(bist_tdata), 0);
      chk("idle_runs", int'({tx_run, rx_run}), 0);
      chk("idle_results", int'({done, pass, timeout, det_seen}), 0);
      chk("idle_counts", int'({err_cnt, rx_cnt}), 0);

      n_bytes = 16'd0;
      start = 1'b1;
      @(negedge clk_h);
      start = 1'b0;
      chk("start_n0_ignored", int'(busy), 0);

      n_bytes = 16'd4;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk_h);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start_idle", int'({busy, switch_on}), 0);

      foreach (vecs[i]) run_test(vecs[i]);

      setup_env(vecs[1]);
      n_bytes = 16'd8;
      start = 1'b1;
      @(negedge clk_h);
      start = 1'b0;
      k = 0;
      while (!tx_run && k < 100) begin
         @(negedge clk_h);
         k++;
      end
      chk("abort_reached_tx", int'(tx_run), 1);
      abort = 1'b1;
      @(negedge clk_h);
      abort = 1'b0;
      chk("abort_enables", int'({switch_on, tx_run, rx_run, bist_tvalid}), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_pass", int'(pass), 0);
      seen = done;
      repeat (30) begin
         @(negedge clk_h);
         seen |= done;
      end
      chk("abort_no_done", int'(seen), 0);
      chk("abort_rx_discarded", int'(rx_cnt), 0);
      chk("abort_err_kept", int'(err_cnt), 0);

      setup_env(vecs[0]);
      n_bytes = 16'd4;
      start = 1'b1;
      @(negedge clk_h);
      start = 1'b0;
      k = 0;
      while (!rx_run && k < 100) begin
         @(negedge clk_h);
         k++;
      end
      chk("rst_mid_reached_rx", int'(rx_run), 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_enables", int'({switch_on, tx_run, rx_run, busy}), 0);
      chk("rst_mid_rx_tready", int'(rx_tready), 0);
      @(negedge clk_h);
      rst = 1'b0;
      @(negedge clk_h);
      run_test(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
